// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbiter that multiplexes p_num_ports valid/ready
// input streams into one registered output stream. A single output register
// holds the winning message; the rotating priority pointer advances to one
// past the port that last transferred, so every requester is served in turn.
module rr_arb_mux #(
  parameter type t_data      = logic [31:0],
  parameter int  p_num_ports = 4,
  parameter int  p_sel_bits  = $clog2(p_num_ports)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  t_data                  istream_msg [p_num_ports],
  input  logic [p_num_ports-1:0] istream_val,
  output logic [p_num_ports-1:0] istream_rdy,
  output t_data                  ostream_msg,
  output logic [p_sel_bits-1:0]  ostream_sel,
  output logic                   ostream_val,
  input  logic                   ostream_rdy
);

  // Output register and rotating priority pointer
  t_data                 msg_q, msg_d;
  logic [p_sel_bits-1:0] sel_q, sel_d;
  logic                  full_q, full_d;
  logic [p_sel_bits-1:0] ptr_q, ptr_d;

  // Arbitration results
  logic                  gnt_vld;
  logic [p_sel_bits-1:0] gnt_idx;
  logic [p_sel_bits-1:0] gnt_nxt;
  logic                  space;
  logic                  xfer;
  int                    cand;

  // Scan ports starting at ptr, wrapping modulo p_num_ports; first valid wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < p_num_ports; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= p_num_ports) cand = cand - p_num_ports;
      if (!gnt_vld && istream_val[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = p_sel_bits'(cand);
      end
    end
  end

  // Handshake: the register accepts when empty or being drained this cycle.
  // Reset masks ready so a message offered during reset is never consumed.
  always_comb begin
    space       = !full_q || ostream_rdy;
    xfer        = gnt_vld && space && !rst;
    istream_rdy = '0;
    if (xfer) istream_rdy[gnt_idx] = 1'b1;
    // Explicit wrap so a non-power-of-two port count never leaves range.
    if (gnt_idx == p_sel_bits'(p_num_ports - 1)) gnt_nxt = '0;
    else                                         gnt_nxt = gnt_idx + p_sel_bits'(1);
  end

  // Next state: load on transfer (also covers dequeue+refill), clear on drain.
  always_comb begin
    msg_d  = msg_q;
    sel_d  = sel_q;
    full_d = full_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      msg_d  = istream_msg[gnt_idx];
      sel_d  = gnt_idx;
      full_d = 1'b1;
      ptr_d  = gnt_nxt;
    end else if (full_q && ostream_rdy) begin
      full_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset also clears the buffered data.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q  <= '0;
      sel_q  <= '0;
      full_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      msg_q  <= msg_d;
      sel_q  <= sel_d;
      full_q <= full_d;
      ptr_q  <= ptr_d;
    end
  end

  assign ostream_msg = msg_q;
  assign ostream_sel = sel_q;
  assign ostream_val = full_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-port instance for the main scenarios and
// a 3-port instance for the non-power-of-two wrap.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-port instance
  logic        rst;
  logic [31:0] msg [4];
  logic [3:0]  val;
  logic [3:0]  rdy;
  logic [31:0] omsg;
  logic [1:0]  osel;
  logic        oval;
  logic        ordy;

  // 3-port instance
  logic        rst3;
  logic [31:0] msg3 [3];
  logic [2:0]  val3;
  logic [2:0]  rdy3;
  logic [31:0] omsg3;
  logic [1:0]  osel3;
  logic        oval3;
  logic        ordy3;

  int n_vec = 0;
  int n_bad = 0;

  rr_arb_mux #(.t_data(logic [31:0]), .p_num_ports(4)) dut (
    .clk(clk), .rst(rst),
    .istream_msg(msg), .istream_val(val), .istream_rdy(rdy),
    .ostream_msg(omsg), .ostream_sel(osel), .ostream_val(oval), .ostream_rdy(ordy)
  );

  rr_arb_mux #(.t_data(logic [31:0]), .p_num_ports(3)) dut3 (
    .clk(clk), .rst(rst3),
    .istream_msg(msg3), .istream_val(val3), .istream_rdy(rdy3),
    .ostream_msg(omsg3), .ostream_sel(osel3), .ostream_val(oval3), .ostream_rdy(ordy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e4;
  logic [2:0] e3;

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    val = '0; val3 = '0; ordy = 1'b0; ordy3 = 1'b0;
    for (int i = 0; i < 4; i++) msg[i] = 32'hA5A5_0000 + i;
    for (int i = 0; i < 3; i++) msg3[i] = 32'h0000_0300 + i;
    tick(); tick();

    // Reset state
    chk("rst_val", oval, 0);
    chk("rst_msg", omsg, 0);
    chk("rst_sel", osel, 0);
    chk("rst_rdy_idle", rdy, 0);
    val = 4'hF; ordy = 1'b1; val3 = 3'h7; ordy3 = 1'b1;
    #1;
    chk("rst_rdy_req", rdy, 0);
    chk("rst_rdy_req3", rdy3, 0);
    tick();
    chk("rst_no_accept", oval, 0);
    rst = 1'b0; rst3 = 1'b0; val = '0; val3 = '0;

    // Single request from port 2
    val = 4'b0100;
    #1;
    chk("single_rdy", rdy, 4'b0100);
    tick();
    val = '0;
    #1;
    chk("single_val", oval, 1);
    chk("single_msg", omsg, 32'hA5A5_0002);
    chk("single_sel", osel, 2);
    tick();
    chk("single_drain", oval, 0);

    // Re-reset so priority restarts at port 0, then all ports valid
    rst = 1'b1;
    tick();
    rst = 1'b0; val = 4'hF;
    #1;
    chk("rr_rdy_first", rdy, 4'b0001);
    for (int c = 0; c < 6; c++) begin
      tick();
      e4 = 4'b0001 << ((c + 1) % 4);
      chk("rr_sel", osel, c % 4);
      chk("rr_val", oval, 1);
      chk("rr_msg", omsg, 32'hA5A5_0000 + (c % 4));
      chk("rr_rdy", rdy, e4);
    end
    val = '0;

    // Backpressure: fill from port 0 with 0x11 (ptr -> 1), then stall
    tick();
    chk("bp_empty", oval, 0);
    msg[0] = 32'h11; val = 4'b0001; ordy = 1'b0;
    #1;
    chk("bp_fill_rdy", rdy, 4'b0001);
    tick();
    val = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", rdy, 0);
      chk("bp_msg", omsg, 32'h11);
      chk("bp_sel", osel, 0);
      chk("bp_val", oval, 1);
      if (i < 2) tick();
    end
    ordy = 1'b1;
    #1;
    chk("bp_release_rdy", rdy, 4'b0010);
    tick();
    val = 4'b1000;
    #1;
    chk("bp_p1_sel", osel, 1);
    chk("bp_p1_msg", omsg, 32'hA5A5_0001);
    chk("bp_p3_rdy", rdy, 4'b1000);
    tick();
    val = '0;
    #1;
    chk("bp_p3_sel", osel, 3);
    chk("bp_p3_msg", omsg, 32'hA5A5_0003);

    // Fairness skip: grant port 0 (ptr -> 1), then ports 0 and 3 valid
    val = 4'b0001;
    tick();
    val = 4'b1001;
    #1;
    chk("skip_rdy3", rdy, 4'b1000);
    tick();
    chk("skip_sel3", osel, 3);
    chk("skip_rdy0", rdy, 4'b0001);
    tick();
    val = '0;
    #1;
    chk("skip_sel0", osel, 0);

    // Mid-operation reset with a buffered message
    msg[2] = 32'hDEAD_BEEF; val = 4'b0100; ordy = 1'b1;
    tick();
    val = '0; ordy = 1'b0;
    #1;
    chk("mr_msg", omsg, 32'hDEAD_BEEF);
    chk("mr_full", oval, 1);
    rst = 1'b1;
    tick();
    chk("mr_val", oval, 0);
    chk("mr_sel", osel, 0);
    chk("mr_msg0", omsg, 0);
    rst = 1'b0; val = 4'hF; ordy = 1'b1;
    #1;
    chk("mr_prio_rdy", rdy, 4'b0001);
    tick();
    val = '0;
    #1;
    chk("mr_prio_sel", osel, 0);

    // Three ports: wrap from 2 back to 0
    val3 = 3'b111; ordy3 = 1'b1;
    #1;
    chk("n3_rdy_first", rdy3, 3'b001);
    for (int c = 0; c < 6; c++) begin
      tick();
      e3 = 3'b001 << ((c + 1) % 3);
      chk("n3_sel", osel3, c % 3);
      chk("n3_msg", omsg3, 32'h0000_0300 + (c % 3));
      chk("n3_val", oval3, 1);
      chk("n3_rdy", rdy3, e3);
    end
    val3 = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
